matrix_processor: RTL and testbench
===================================

MATRIX_PROCESSOR -- requirements
Module: matrix_processor

Interface
REQ-001 Parameter N, default 8, matrix dimension (N x N operands, N >= 1).
REQ-002 Parameter DW, default 8, signed two's-complement data width.
REQ-003 Parameter AW, default 7, memory address width.
REQ-004 Parameter FRAC, default 4, fractional bits of the fixed-point format.
REQ-005 Parameter RD_LAT, default 1, memory read latency in cycles (1..3).
REQ-006 Parameters X_BASE/W_BASE/Y_BASE, defaults 0/0/64, base addresses of X (RAM), W (ROM) and Y (RAM).
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  single-cycle request to begin a computation.
REQ-010 mode  in  2  activation select: 00 identity, 01 ReLU, 10 hard-tanh, 11 identity.
REQ-011 busy  out  1  high from the cycle after an accepted start until done.
REQ-012 done  out  1  one-cycle pulse after the last Y write.
REQ-013 csb  out  2  active-low selects: bit0 RAM, bit1 ROM; 2'b11 idle.
REQ-014 web  out  1  RAM write enable, active-low.
REQ-015 addr  out  AW  shared memory address.
REQ-016 dout  out  DW  RAM write data.
REQ-017 dinx  in  DW  RAM read data.
REQ-018 dinw  in  DW  ROM read data.

Function
REQ-019 Computes Y[i][j] = act(sat(sum over k of W[i][k]*X[k][j] >>> FRAC)), for i,j,k in 0..N-1.
REQ-020 Addresses: X at X_BASE+k*N+j, W at W_BASE+i*N+k, Y at Y_BASE+i*N+j, all modulo 2^AW.
REQ-021 FSM states: IDLE, RD_W, WAIT_W, RD_X, WAIT_X, ACC, POST, WR, DONE.
REQ-022 IDLE -> RD_W on start; mode is latched at that edge; start while busy is ignored.
REQ-023 RD_W drives csb=2'b01 (ROM only) with the W address for one cycle; WAIT_W holds csb=2'b11 and samples dinw exactly RD_LAT cycles after RD_W.
REQ-024 RD_X/WAIT_X behave identically using csb=2'b10 (RAM only), web=1 and dinx.
REQ-025 ACC adds the signed DW x DW product to an accumulator of 2*DW+clog2(N) bits; no overflow can occur.
REQ-026 After k = N-1, ACC -> POST; otherwise ACC -> RD_W with k+1.
REQ-027 POST: arithmetic right shift by FRAC (rounds toward minus infinity), saturate to [-2^(DW-1), 2^(DW-1)-1], then apply act.
REQ-028 ReLU maps negatives to 0; hard-tanh clamps to [-2^FRAC, 2^FRAC] after saturation.
REQ-029 WR drives csb=2'b10, web=0, the Y address and dout for exactly one cycle, then clears the accumulator.
REQ-030 Element order is row-major (j fastest, then i); WR -> RD_W for the next element, or -> DONE after element (N-1,N-1).
REQ-031 DONE pulses done for one cycle, drops busy and returns to IDLE; start is accepted again in the next cycle.
REQ-032 csb is never 2'b00; web=0 only in WR; addr and dout are 0 whenever csb=2'b11.
REQ-033 Latency per element is 2N*(RD_LAT+1)+N+2 cycles; total is N^2 times that plus 1.

Reset
REQ-034 rst low asynchronously forces IDLE, csb=2'b11, web=1, addr=0, dout=0, busy=0, done=0, and clears all counters and the accumulator.
REQ-035 Reset during a computation abandons it with no further writes; a start issued after reset release runs from element (0,0).

Structure
REQ-036 Package matrix_processor_pkg holds the state enumeration, the mode encodings and the CSB_IDLE/CSB_RAM/CSB_ROM constants.
REQ-037 One sub-module, mp_mac_sat, contains the multiply-accumulate, shift, saturation and activation datapath; the FSM and address generation stay in matrix_processor.

Verification
REQ-038 N=2, FRAC=4, W=identity(16), X=[[16,32],[-16,48]], mode 00 -> writes 16,32,-16,48 to addresses 64..67, then one done pulse.
REQ-039 N=2, W all 127, X all 127, mode 00 -> every Y equals 127 (saturation); with X all -128, every Y equals -128.
REQ-040 Same data as REQ-038, mode 01 -> Y=16,32,0,48; mode 10 with X entry 48 -> that output clamps to 16.
REQ-041 RD_LAT=3 -> dinw/dinx are sampled exactly 3 cycles after select, total cycle count matches REQ-033, and csb is never 2'b00.
REQ-042 rst asserted mid-ACC of element (1,0) -> outputs reach reset values immediately and the pending write never occurs; a later start recomputes from (0,0).
REQ-043 start pulsed while busy -> ignored; start one cycle after done -> a second run produces identical results.

Source files
------------

// File: rtl/matrix_processor_pkg.sv
// Shared types for the fixed-point matrix processor: FSM states, activation
// modes and the active-low memory select encodings.
package matrix_processor_pkg;

  typedef enum logic [3:0] {
    IDLE, RD_W, WAIT_W, RD_X, WAIT_X, ACC, POST, WR, DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_ID    = 2'b00,
    MODE_RELU  = 2'b01,
    MODE_HTANH = 2'b10,
    MODE_ID2   = 2'b11
  } mode_e;

  // bit0 selects RAM, bit1 selects ROM, both active-low
  localparam logic [1:0] CSB_IDLE = 2'b11;
  localparam logic [1:0] CSB_RAM  = 2'b10;
  localparam logic [1:0] CSB_ROM  = 2'b01;

endpackage

// File: rtl/mp_mac_sat.sv
// Signed multiply-accumulate followed by arithmetic shift, saturation to the
// output width and the selected activation; result registered in POST.
module mp_mac_sat
  import matrix_processor_pkg::*;
#(
  parameter int N    = 8,
  parameter int DW   = 8,
  parameter int FRAC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_en,
  input  logic                 post_en,
  input  logic                 clr,
  input  mode_e                mode,
  input  logic signed [DW-1:0] w,
  input  logic signed [DW-1:0] x,
  output logic signed [DW-1:0] y
);

  localparam int ACCW = 2*DW + $clog2(N);
  localparam logic signed [DW-1:0] YMAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] YMIN   = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] HT_MAX = DW'(1 << FRAC);
  localparam logic signed [DW-1:0] HT_MIN = -HT_MAX;

  logic signed [ACCW-1:0] acc_q, acc_d, sh;
  logic signed [2*DW-1:0] prod;
  logic signed [DW-1:0]   sat, act, y_q, y_d;

  always_comb begin
    prod  = w * x;
    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (acc_en) acc_d = acc_q + ACCW'(prod);

    // >>> floors, so negative results round toward minus infinity
    sh = acc_q >>> FRAC;
    if (sh > ACCW'(YMAX))      sat = YMAX;
    else if (sh < ACCW'(YMIN)) sat = YMIN;
    else                       sat = sh[DW-1:0];

    act = sat;
    unique case (mode)
      MODE_RELU:  act = (sat < 0) ? '0 : sat;
      MODE_HTANH: act = (sat > HT_MAX) ? HT_MAX : ((sat < HT_MIN) ? HT_MIN : sat);
      default:    act = sat;
    endcase

    y_d = post_en ? act : y_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/matrix_processor.sv
// Sequential N x N fixed-point matrix product Y = act(sat(W*X >>> FRAC)) over a
// shared single-port memory bus; one MAC per operand pair, row-major output.
module matrix_processor
  import matrix_processor_pkg::*;
#(
  parameter int N      = 8,
  parameter int DW     = 8,
  parameter int AW     = 7,
  parameter int FRAC   = 4,
  parameter int RD_LAT = 1,
  parameter int X_BASE = 0,
  parameter int W_BASE = 0,
  parameter int Y_BASE = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic [1:0]    csb,
  output logic          web,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] dout,
  input  logic [DW-1:0] dinx,
  input  logic [DW-1:0] dinw
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [1:0]    WLAST = 2'(RD_LAT - 1);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [CW-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic [1:0]           wt_q, wt_d;
  logic signed [DW-1:0] w_q, w_d, x_q, x_d, y;
  logic [AW-1:0]        w_addr, x_addr, y_addr;

  assign w_addr = AW'(W_BASE) + AW'(i_q) * AW'(N) + AW'(k_q);
  assign x_addr = AW'(X_BASE) + AW'(k_q) * AW'(N) + AW'(j_q);
  assign y_addr = AW'(Y_BASE) + AW'(i_q) * AW'(N) + AW'(j_q);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    wt_d    = wt_q;
    w_d     = w_q;
    x_d     = x_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = RD_W;
        mode_d  = mode_e'(mode);
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        wt_d    = '0;
      end
      RD_W: state_d = WAIT_W;
      // data from a select becomes valid in the last wait cycle
      WAIT_W: if (wt_q == WLAST) begin
        w_d     = dinw;
        wt_d    = '0;
        state_d = RD_X;
      end else wt_d = wt_q + 2'd1;
      RD_X: state_d = WAIT_X;
      WAIT_X: if (wt_q == WLAST) begin
        x_d     = dinx;
        wt_d    = '0;
        state_d = ACC;
      end else wt_d = wt_q + 2'd1;
      ACC: if (k_q == LAST) begin
        k_d     = '0;
        state_d = POST;
      end else begin
        k_d     = k_q + CW'(1);
        state_d = RD_W;
      end
      POST: state_d = WR;
      WR: begin
        state_d = RD_W;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else i_d = i_q + CW'(1);
        end else j_d = j_q + CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE) && (state_q != DONE);
    done = (state_q == DONE);
    csb  = CSB_IDLE;
    web  = 1'b1;
    addr = '0;
    dout = '0;
    unique case (state_q)
      RD_W: begin
        csb  = CSB_ROM;
        addr = w_addr;
      end
      RD_X: begin
        csb  = CSB_RAM;
        addr = x_addr;
      end
      WR: begin
        csb  = CSB_RAM;
        web  = 1'b0;
        addr = y_addr;
        dout = y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_ID;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      wt_q    <= '0;
      w_q     <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      wt_q    <= wt_d;
      w_q     <= w_d;
      x_q     <= x_d;
    end
  end

  mp_mac_sat #(.N(N), .DW(DW), .FRAC(FRAC)) u_mac (
    .clk     (clk),
    .rst     (rst),
    .acc_en  (state_q == ACC),
    .post_en (state_q == POST),
    .clr     (state_q == WR),
    .mode    (mode_q),
    .w       (w_q),
    .x       (x_q),
    .y       (y)
  );

endmodule

// File: tb/tb_matrix_processor.sv
// Scoreboard bench: two DUTs (read latency 1 and 3) share behavioural memories;
// expected Y writes are queued at start and checked as the DUT writes them.
module tb_matrix_processor;

  localparam int N = 2, DW = 8, AW = 7, FRAC = 4, YB = 64;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start [2];
  logic [1:0]    mode  [2];
  logic          busy  [2];
  logic          done  [2];
  logic          web   [2];
  logic [1:0]    csb   [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] dout  [2];
  logic [DW-1:0] dinx  [2];
  logic [DW-1:0] dinw  [2];

  logic signed [DW-1:0] ram [128];
  logic signed [DW-1:0] rom [128];
  logic [DW-1:0] xp [2][3];
  logic [DW-1:0] wp [2][3];

  wr_t sb[$];
  int  tests = 0, fails = 0, proto_err = 0, wr_cnt = 0, cyc = 0, t0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_processor #(.N(N), .DW(DW), .AW(AW), .FRAC(FRAC), .RD_LAT(1),
                     .X_BASE(0), .W_BASE(0), .Y_BASE(YB)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[0]), .mode(mode[0]), .busy(busy[0]),
    .done(done[0]), .csb(csb[0]), .web(web[0]), .addr(addr[0]),
    .dout(dout[0]), .dinx(dinx[0]), .dinw(dinw[0]));

  matrix_processor #(.N(N), .DW(DW), .AW(AW), .FRAC(FRAC), .RD_LAT(3),
                     .X_BASE(0), .W_BASE(0), .Y_BASE(YB)) u_dut3 (
    .clk(clk), .rst(rst), .start(start[1]), .mode(mode[1]), .busy(busy[1]),
    .done(done[1]), .csb(csb[1]), .web(web[1]), .addr(addr[1]),
    .dout(dout[1]), .dinx(dinx[1]), .dinw(dinw[1]));

  // Read pipes carry random junk except exactly RD_LAT cycles after a select
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      wp[g][0] <= (csb[g][1] == 1'b0) ? rom[addr[g]] : DW'($urandom);
      xp[g][0] <= (csb[g][0] == 1'b0 && web[g]) ? ram[addr[g]] : DW'($urandom);
      for (int s = 1; s < 3; s++) begin
        wp[g][s] <= wp[g][s-1];
        xp[g][s] <= xp[g][s-1];
      end
    end
  end
  assign dinw[0] = wp[0][0];
  assign dinx[0] = xp[0][0];
  assign dinw[1] = wp[1][2];
  assign dinx[1] = xp[1][2];

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (csb[g] === 2'b00 || (web[g] === 1'b0 && csb[g] !== 2'b10) ||
            (csb[g] === 2'b11 && (addr[g] !== '0 || dout[g] !== '0)))
          proto_err++;
        if (web[g] === 1'b0 && csb[g] === 2'b10) begin
          wr_cnt++;
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL y_write_unexpected dut%0d: got addr=%0d data=%0d, required no write",
                     g, addr[g], $signed(dout[g]));
          end else begin
            e = sb.pop_front();
            if (addr[g] !== e.addr || dout[g] !== e.data) begin
              fails++;
              $display("FAIL y_write dut%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
                       g, addr[g], $signed(dout[g]), e.addr, $signed(e.data));
            end
          end
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_y(int i, int j, logic [1:0] m);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(rom[i*N+k]) * int'(ram[k*N+j]);
    s = s >>> FRAC;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    if (m == 2'b01 && s < 0) s = 0;
    if (m == 2'b10) begin
      if (s > 16) s = 16;
      else if (s < -16) s = -16;
    end
    return DW'(s);
  endfunction

  function automatic int exp_cyc(int lat);
    return N*N*(2*N*(lat+1) + N + 2) + 1;
  endfunction

  task automatic load(input int w0, w1, w2, w3, x0, x1, x2, x3);
    for (int a = 0; a < 128; a++) begin
      ram[a] = '0;
      rom[a] = '0;
    end
    rom[0] = DW'(w0); rom[1] = DW'(w1); rom[2] = DW'(w2); rom[3] = DW'(w3);
    ram[0] = DW'(x0); ram[1] = DW'(x1); ram[2] = DW'(x2); ram[3] = DW'(x3);
  endtask

  task automatic kick(input int g, input logic [1:0] m);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        sb.push_back('{addr: AW'(YB + i*N + j), data: exp_y(i, j, m)});
    @(negedge clk);
    mode[g]  = m;
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    mode[g]  = ~m;
    t0 = cyc;
  endtask

  task automatic wait_done(input int g, output int ncyc);
    ncyc = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done[g] === 1'b1) begin
        ncyc = cyc - t0 + 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    tests += 6;
    if (csb[0] !== 2'b11)  begin fails++; $display("FAIL reset_csb: got %b, required 11", csb[0]); end
    if (web[0] !== 1'b1)   begin fails++; $display("FAIL reset_web: got %b, required 1", web[0]); end
    if (addr[0] !== '0)    begin fails++; $display("FAIL reset_addr: got %0d, required 0", addr[0]); end
    if (dout[0] !== '0)    begin fails++; $display("FAIL reset_dout: got %0d, required 0", dout[0]); end
    if (busy[0] !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b, required 0", busy[0]); end
    if (done[0] !== 1'b0)  begin fails++; $display("FAIL reset_done: got %b, required 0", done[0]); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_identity;
    int n;
    load(16, 0, 0, 16, 16, 32, -16, 48);
    kick(0, 2'b00);
    @(negedge clk);
    tests++;
    if (busy[0] !== 1'b1) begin fails++; $display("FAIL identity_busy: got %b, required 1", busy[0]); end
    wait_done(0, n);
    tests++;
    if (n !== exp_cyc(1)) begin fails++; $display("FAIL identity_cycles: got %0d, required %0d", n, exp_cyc(1)); end
    @(negedge clk);
    tests += 2;
    if (done[0] !== 1'b0) begin fails++; $display("FAIL identity_done_pulse: got %b, required 0", done[0]); end
    if (sb.size() != 0) begin fails++; $display("FAIL identity_writes: got %0d missing, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_saturation;
    int n;
    load(127, 127, 127, 127, 127, 127, 127, 127);
    kick(0, 2'b00);
    wait_done(0, n);
    load(127, 127, 127, 127, -128, -128, -128, -128);
    kick(0, 2'b00);
    wait_done(0, n);
    tests += 2;
    if (n !== exp_cyc(1)) begin fails++; $display("FAIL sat_cycles: got %0d, required %0d", n, exp_cyc(1)); end
    if (sb.size() != 0) begin fails++; $display("FAIL sat_writes: got %0d missing, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_activation;
    int n;
    load(16, 0, 0, 16, 16, 32, -16, 48);
    kick(0, 2'b01);
    wait_done(0, n);
    kick(0, 2'b10);
    wait_done(0, n);
    // floor rounding of negative quotients, identity via mode 11
    load(1, 0, 0, 1, -1, 17, -17, 31);
    kick(0, 2'b11);
    wait_done(0, n);
    tests += 2;
    if (n !== exp_cyc(1)) begin fails++; $display("FAIL act_cycles: got %0d, required %0d", n, exp_cyc(1)); end
    if (sb.size() != 0) begin fails++; $display("FAIL act_writes: got %0d missing, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_latency3;
    int n;
    load(0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 4; a++) begin
      rom[a] = DW'($urandom);
      ram[a] = DW'($urandom);
    end
    kick(1, 2'b00);
    wait_done(1, n);
    tests += 2;
    if (n !== exp_cyc(3)) begin fails++; $display("FAIL lat3_cycles: got %0d, required %0d", n, exp_cyc(3)); end
    if (sb.size() != 0) begin fails++; $display("FAIL lat3_writes: got %0d missing, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid;
    int n, base, hit;
    load(16, 0, 0, 16, 16, 32, -16, 48);
    base = wr_cnt;
    hit  = 0;
    kick(0, 2'b00);
    for (int c = 0; c < 100 && hit == 0; c++) begin
      @(negedge clk);
      #1;
      if (wr_cnt == base + 2) hit = 1;
    end
    tests++;
    if (hit == 0) begin fails++; $display("FAIL rstmid_reach: got %0d writes, required 2", wr_cnt - base); end
    // RD_W, WAIT_W, RD_X, WAIT_X, then ACC of element (1,0)
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    tests += 4;
    if (csb[0] !== 2'b11 || web[0] !== 1'b1) begin fails++; $display("FAIL rstmid_bus: got csb=%b web=%b, required 11/1", csb[0], web[0]); end
    if (addr[0] !== '0 || dout[0] !== '0)    begin fails++; $display("FAIL rstmid_data: got addr=%0d dout=%0d, required 0/0", addr[0], dout[0]); end
    if (busy[0] !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b, required 0", busy[0]); end
    if (done[0] !== 1'b0) begin fails++; $display("FAIL rstmid_done: got %b, required 0", done[0]); end
    sb.delete();
    base = wr_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    tests++;
    if (wr_cnt != base) begin fails++; $display("FAIL rstmid_no_write: got %0d writes, required 0", wr_cnt - base); end
    kick(0, 2'b00);
    wait_done(0, n);
    tests += 2;
    if (n !== exp_cyc(1)) begin fails++; $display("FAIL rstmid_cycles: got %0d, required %0d", n, exp_cyc(1)); end
    if (sb.size() != 0) begin fails++; $display("FAIL rstmid_writes: got %0d missing, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_back_to_back;
    int n;
    load(16, 0, 0, 16, 16, 32, -16, 48);
    kick(0, 2'b00);
    repeat (3) @(negedge clk);
    mode[0]  = 2'b01;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, n);
    tests++;
    if (n !== exp_cyc(1)) begin fails++; $display("FAIL b2b_ignore_cycles: got %0d, required %0d", n, exp_cyc(1)); end
    kick(0, 2'b00);
    wait_done(0, n);
    tests += 2;
    if (n !== exp_cyc(1)) begin fails++; $display("FAIL b2b_rerun_cycles: got %0d, required %0d", n, exp_cyc(1)); end
    if (sb.size() != 0) begin fails++; $display("FAIL b2b_writes: got %0d missing, required 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_protocol;
    tests++;
    if (proto_err !== 0) begin fails++; $display("FAIL bus_protocol: got %0d violating cycles, required 0", proto_err); end
  endtask

  initial begin
    start[0] = 1'b0; start[1] = 1'b0;
    mode[0]  = 2'b00; mode[1]  = 2'b00;
    test_reset;
    test_identity;
    test_saturation;
    test_activation;
    test_latency3;
    test_reset_mid;
    test_back_to_back;
    test_protocol;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
